ex_stage: RTL and testbench



---
 rtl/ex_pkg.sv | 50 +++++
 rtl/ex_divider.sv | 98 +++++++++
 rtl/ex_stage.sv | 90 +++++++++
 tb/tb_ex_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op codes, forwarding selects,
// divider state encoding and the operand forwarding helper.
package ex_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_PASSB = 4'b1010,
    ALU_RSVD  = 4'b1011,
    ALU_DIV   = 4'b1100,
    ALU_DIVU  = 4'b1101,
    ALU_REM   = 4'b1110,
    ALU_REMU  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_REG2 = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_RUN  = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel,
                                              input logic [XLEN-1:0] reg_v,
                                              input logic [XLEN-1:0] wb_v,
                                              input logic [XLEN-1:0] mem_v);
    case (sel)
      FWD_WB:  fwd_mux = wb_v;
      FWD_MEM: fwd_mux = mem_v;
      default: fwd_mux = reg_v;
    endcase
  endfunction

endpackage

// File: rtl/ex_divider.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// sign correction applied when the final bit is produced.
module ex_divider
  import ex_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [1:0]      op_i,     // bit1: remainder, bit0: unsigned
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  div_state_e      state_q;
  logic [4:0]      count_q;
  logic [XLEN-1:0] quo_q, dvs_q, result_q;
  logic [XLEN:0]   rem_q;
  logic            neg_q_q, neg_r_q, rem_sel_q, dvz_q;

  logic [XLEN:0]   rem_shift, diff, rem_d;
  logic [XLEN-1:0] quo_d, q_fix, r_fix, result_d;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_neg = ~op_i[0] & a_i[XLEN-1];
  assign b_neg = ~op_i[0] & b_i[XLEN-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  always_comb begin
    rem_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    rem_d     = rem_shift;
    quo_d     = {quo_q[XLEN-2:0], 1'b0};
    if (!diff[XLEN]) begin
      rem_d = diff;
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end
    // A zero divisor always reports all-ones, whatever the operand signs.
    q_fix    = dvz_q ? '1 : (neg_q_q ? -quo_d : quo_d);
    r_fix    = neg_r_q ? -rem_d[XLEN-1:0] : rem_d[XLEN-1:0];
    result_d = rem_sel_q ? r_fix : q_fix;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= DIV_IDLE;
      count_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      dvz_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            quo_q     <= a_mag;
            rem_q     <= '0;
            dvs_q     <= b_mag;
            neg_q_q   <= a_neg ^ b_neg;
            neg_r_q   <= a_neg;
            rem_sel_q <= op_i[1];
            dvz_q     <= (b_i == '0);
            count_q   <= '0;
            state_q   <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          if (abort_i) begin
            state_q <= DIV_IDLE;
          end else begin
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            count_q <= count_q + 5'd1;
            if (count_q == 5'd31) begin
              result_q <= result_d;
              state_q  <= DIV_DONE;
            end
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign busy_o   = start_i & (state_q != DIV_DONE);
  assign done_o   = (state_q == DIV_DONE);
  assign result_o = result_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, branch resolution and,
// when EX_DIV_EN is defined, a multi-cycle divider that stalls the pipeline.
module ex_stage
  import ex_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            Valid_E,
  input  logic [3:0]      ALUControl_E,
  input  logic            ALUSrc_E,
  input  logic            Jump_E,
  input  logic            Branch_E,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Extimm_E,
  input  logic [XLEN-1:0] PC_E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] ALUResult_M,
  input  logic [XLEN-1:0] Result_W,
  output logic [XLEN-1:0] ALUResult_E,
  output logic [XLEN-1:0] WriteData_E,
  output logic [XLEN-1:0] PCTarget_E,
  output logic            PCSrc_E,
  output logic            Busy_E
);

  logic [XLEN-1:0] src_a, src_b, div_value;
  logic [4:0]      shamt;
  logic            zero;

  assign src_a       = fwd_mux(ForwardA_E, RD1_E, Result_W, ALUResult_M);
  assign WriteData_E = fwd_mux(ForwardB_E, RD2_E, Result_W, ALUResult_M);
  assign src_b       = ALUSrc_E ? Extimm_E : WriteData_E;
  assign shamt       = src_b[4:0];

  // Branch compare is independent of the selected ALU op.
  assign zero       = ((src_a - src_b) == '0);
  assign PCSrc_E    = Jump_E | (Branch_E & zero);
  assign PCTarget_E = PC_E + Extimm_E;

`ifdef EX_DIV_EN
  logic            div_op, div_busy, div_done;
  logic [XLEN-1:0] div_result;

  assign div_op = Valid_E & (ALUControl_E[3:2] == 2'b11);

  ex_divider u_div (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (div_op),
    .abort_i  (~Valid_E),
    .a_i      (src_a),
    .b_i      (src_b),
    .op_i     (ALUControl_E[1:0]),
    .busy_o   (div_busy),
    .done_o   (div_done),
    .result_o (div_result)
  );

  assign Busy_E    = div_busy;
  assign div_value = div_done ? div_result : '0;
`else
  logic unused_div_inputs;

  assign unused_div_inputs = clk ^ reset ^ Valid_E;
  assign Busy_E            = 1'b0;
  assign div_value         = '1;
`endif

  always_comb begin
    ALUResult_E = '0;
    case (alu_op_e'(ALUControl_E))
      ALU_ADD:   ALUResult_E = src_a + src_b;
      ALU_SUB:   ALUResult_E = src_a - src_b;
      ALU_AND:   ALUResult_E = src_a & src_b;
      ALU_OR:    ALUResult_E = src_a | src_b;
      ALU_XOR:   ALUResult_E = src_a ^ src_b;
      ALU_SLT:   ALUResult_E = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU:  ALUResult_E = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      ALU_SLL:   ALUResult_E = src_a << shamt;
      ALU_SRL:   ALUResult_E = src_a >> shamt;
      ALU_SRA:   ALUResult_E = $unsigned($signed(src_a) >>> shamt);
      ALU_PASSB: ALUResult_E = src_b;
      ALU_RSVD:  ALUResult_E = '0;
      default:   ALUResult_E = div_value;
    endcase
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage; divider scenarios are compiled in with EX_DIV_EN.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Valid_E;
  logic [3:0]  ALUControl_E;
  logic        ALUSrc_E, Jump_E, Branch_E;
  logic [31:0] RD1_E, RD2_E, Extimm_E, PC_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic [31:0] ALUResult_M, Result_W;
  logic [31:0] ALUResult_E, WriteData_E, PCTarget_E;
  logic        PCSrc_E, Busy_E;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk          (clk),
    .reset        (reset),
    .Valid_E      (Valid_E),
    .ALUControl_E (ALUControl_E),
    .ALUSrc_E     (ALUSrc_E),
    .Jump_E       (Jump_E),
    .Branch_E     (Branch_E),
    .RD1_E        (RD1_E),
    .RD2_E        (RD2_E),
    .Extimm_E     (Extimm_E),
    .PC_E         (PC_E),
    .ForwardA_E   (ForwardA_E),
    .ForwardB_E   (ForwardB_E),
    .ALUResult_M  (ALUResult_M),
    .Result_W     (Result_W),
    .ALUResult_E  (ALUResult_E),
    .WriteData_E  (WriteData_E),
    .PCTarget_E   (PCTarget_E),
    .PCSrc_E      (PCSrc_E),
    .Busy_E       (Busy_E)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] T_OP [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                       4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'h5, 4'h6};
  localparam logic [31:0] T_A [14] = '{32'hFFFF_FFFF, 32'h5, 32'hF0F0_1234, 32'hF0F0_1234,
                                       32'hF0F0_1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                       32'h8000_0010, 32'h8000_0010, 32'h8000_0010,
                                       32'h1234, 32'h1, 32'h1, 32'h1};
  localparam logic [31:0] T_B [14] = '{32'h1, 32'h7, 32'h0FF0_00FF, 32'h0FF0_00FF,
                                       32'h0FF0_00FF, 32'h1, 32'h1, 32'h24, 32'h24, 32'h24,
                                       32'h24, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [31:0] T_EXP [14] = '{32'h0, 32'hFFFF_FFFE, 32'h00F0_0034, 32'hFFF0_12FF,
                                         32'hFF00_12CB, 32'h1, 32'h0, 32'h0000_0100,
                                         32'h0800_0001, 32'hF800_0001, 32'h24, 32'h0,
                                         32'h0, 32'h1};

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic src, input logic [31:0] imm);
    Valid_E      = 1'b1;
    ALUControl_E = op;
    RD1_E        = a;
    RD2_E        = b;
    ALUSrc_E     = src;
    Extimm_E     = imm;
    ForwardA_E   = 2'b00;
    ForwardB_E   = 2'b00;
    Jump_E       = 1'b0;
    Branch_E     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(4'h0, 32'd3, 32'd4, 1'b0, 32'd0);
    Valid_E     = 1'b0;
    PC_E        = 32'h0;
    ALUResult_M = 32'h0;
    Result_W    = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (Busy_E !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b exp 0", Busy_E);
    end
    checks++;
    if (ALUResult_E !== 32'd7) begin
      errors++; $display("FAIL reset_alu got %h exp %h", ALUResult_E, 32'd7);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (Busy_E !== 1'b0) begin
      errors++; $display("FAIL post_reset_busy got %b exp 0", Busy_E);
    end
  endtask

  task automatic test_add_imm();
    @(negedge clk);
    drive(4'h0, 32'd5, 32'd9, 1'b1, 32'd7);
    #1;
    checks++;
    if (ALUResult_E !== 32'd12) begin
      errors++; $display("FAIL add_imm got %h exp %h", ALUResult_E, 32'd12);
    end
    checks++;
    if (Busy_E !== 1'b0) begin
      errors++; $display("FAIL add_imm_busy got %b exp 0", Busy_E);
    end
    checks++;
    if (WriteData_E !== 32'd9) begin
      errors++; $display("FAIL add_imm_wdata got %h exp %h", WriteData_E, 32'd9);
    end
  endtask

  task automatic test_forward_branch();
    @(negedge clk);
    drive(4'h1, 32'h0, 32'h1, 1'b0, 32'h0);
    ForwardA_E  = 2'b10;
    ALUResult_M = 32'h10;
    Result_W    = 32'h55;
    #1;
    checks++;
    if (ALUResult_E !== 32'hF) begin
      errors++; $display("FAIL fwd_mem_sub got %h exp %h", ALUResult_E, 32'hF);
    end
    ForwardB_E = 2'b01;
    #1;
    checks++;
    if (WriteData_E !== 32'h55) begin
      errors++; $display("FAIL fwd_wb_wdata got %h exp %h", WriteData_E, 32'h55);
    end
    checks++;
    if (ALUResult_E !== 32'hFFFF_FFBB) begin
      errors++; $display("FAIL fwd_wb_sub got %h exp %h", ALUResult_E, 32'hFFFF_FFBB);
    end
    ForwardA_E = 2'b11;
    ForwardB_E = 2'b11;
    RD1_E      = 32'h30;
    #1;
    checks++;
    if (ALUResult_E !== 32'h2F) begin
      errors++; $display("FAIL fwd_11_reg got %h exp %h", ALUResult_E, 32'h2F);
    end

    @(negedge clk);
    drive(4'h0, 32'h20, 32'h20, 1'b0, 32'h40);
    Branch_E = 1'b1;
    PC_E     = 32'h100;
    #1;
    checks++;
    if (PCSrc_E !== 1'b1) begin
      errors++; $display("FAIL branch_taken got %b exp 1", PCSrc_E);
    end
    checks++;
    if (PCTarget_E !== 32'h140) begin
      errors++; $display("FAIL branch_target got %h exp %h", PCTarget_E, 32'h140);
    end
    RD2_E = 32'h21;
    #1;
    checks++;
    if (PCSrc_E !== 1'b0) begin
      errors++; $display("FAIL branch_not_taken got %b exp 0", PCSrc_E);
    end
    Branch_E = 1'b0;
    Jump_E   = 1'b1;
    #1;
    checks++;
    if (PCSrc_E !== 1'b1) begin
      errors++; $display("FAIL jump got %b exp 1", PCSrc_E);
    end
  endtask

  task automatic test_alu_ops();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(T_OP[i], T_A[i], T_B[i], 1'b0, 32'h0);
      #1;
      checks++;
      if (ALUResult_E !== T_EXP[i]) begin
        errors++;
        $display("FAIL alu_op%0d ctrl %h got %h exp %h", i, T_OP[i], ALUResult_E, T_EXP[i]);
      end
    end
  endtask

`ifdef EX_DIV_EN
  task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output logic [31:0] res);
    @(negedge clk);
    drive(op, a, b, 1'b0, 32'h0);
    #1;
    cycles = 0;
    while (Busy_E === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
      #1;
    end
    res     = ALUResult_E;
    Valid_E = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divide();
    localparam logic [3:0]  D_OP [6]  = '{4'hC, 4'hE, 4'hD, 4'hF, 4'hC, 4'hE};
    localparam logic [31:0] D_A [6]   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                          32'h8000_0000, 32'h8000_0000};
    localparam logic [31:0] D_B [6]   = '{32'd2, 32'd2, 32'd0, 32'd0,
                                          32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [31:0] D_EXP [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                          32'd100, 32'h8000_0000, 32'h0};
    int          cyc;
    logic [31:0] res;
    for (int i = 0; i < 6; i++) begin
      run_div(D_OP[i], D_A[i], D_B[i], cyc, res);
      checks++;
      if (cyc != 33) begin
        errors++; $display("FAIL div%0d_latency got %0d exp 33", i, cyc);
      end
      checks++;
      if (res !== D_EXP[i]) begin
        errors++; $display("FAIL div%0d_result got %h exp %h", i, res, D_EXP[i]);
      end
    end
  endtask

  task automatic test_div_reset_abort();
    int          cyc;
    logic [31:0] res;
    @(negedge clk);
    drive(4'hC, 32'd50, 32'd3, 1'b0, 32'h0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (dut.u_div.state_q !== DIV_IDLE) begin
      errors++; $display("FAIL reset_mid_div state got %0d exp %0d", dut.u_div.state_q, DIV_IDLE);
    end
    reset   = 1'b0;
    Valid_E = 1'b0;
    @(negedge clk);
    run_div(4'hD, 32'd100, 32'd7, cyc, res);
    checks++;
    if (cyc != 33 || res !== 32'd14) begin
      errors++; $display("FAIL div_after_reset got %h/%0d exp %h/33", res, cyc, 32'd14);
    end

    @(negedge clk);
    drive(4'hE, 32'd50, 32'd3, 1'b0, 32'h0);
    repeat (5) @(negedge clk);
    Valid_E = 1'b0;
    #1;
    checks++;
    if (Busy_E !== 1'b0) begin
      errors++; $display("FAIL abort_busy got %b exp 0", Busy_E);
    end
    @(negedge clk);
    #1;
    checks++;
    if (dut.u_div.state_q !== DIV_IDLE) begin
      errors++; $display("FAIL abort_state got %0d exp %0d", dut.u_div.state_q, DIV_IDLE);
    end
    run_div(4'hF, 32'd100, 32'd7, cyc, res);
    checks++;
    if (cyc != 33 || res !== 32'd2) begin
      errors++; $display("FAIL rem_after_abort got %h/%0d exp %h/33", res, cyc, 32'd2);
    end
  endtask
`else
  task automatic test_div_disabled();
    for (int op = 12; op < 16; op++) begin
      @(negedge clk);
      drive(4'(op), 32'd10, 32'd2, 1'b0, 32'h0);
      #1;
      checks++;
      if (ALUResult_E !== 32'hFFFF_FFFF) begin
        errors++; $display("FAIL div_off_op%0d got %h exp ffffffff", op, ALUResult_E);
      end
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        #1;
        checks++;
        if (Busy_E !== 1'b0) begin
          errors++; $display("FAIL div_off_busy op%0d cyc%0d got %b exp 0", op, c, Busy_E);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add_imm();
    test_forward_branch();
    test_alu_ops();
`ifdef EX_DIV_EN
    test_divide();
    test_div_reset_abort();
`else
    test_div_disabled();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
